hpi_bus_ctrl: RTL and testbench
===============================

// Module: hpi_bus_ctrl
// PURPOSE
//   Timing controller between the SoC's software-driven OTG HPI PIO ports and the
//   CY7C67200 USB controller pins. Sits directly downstream of the SoC.
//   Converts PIO level writes (address, cs, r, w, data) into one cleanly timed HPI
//   bus cycle with set-up, strobe, hold and recovery phases.
//   Registers read data back to the SoC's HPI data-in port.
// PARAMETERS
//   SETUP_CYC    2    cycles address/cs (and write data) precede the strobe, 1..15
//   STROBE_CYC   4    cycles rd_n/wr_n held low, 1..15
//   HOLD_CYC     1    cycles cs/addr/data held after strobe release, 1..15
//   RECOVER_CYC  6    cycles cs_n high before the next access may start, 1..15
//   RST_CYC      100  cycles otg_rst_n held low after reset release, 1..255
// PORTS
//   clk_clk        in     1   system clock (50 MHz)
//   reset_reset_n  in     1   asynchronous active-low reset
//   hpi_address_i  in     2   from otg_hpi_address_export
//   hpi_cs_i       in     1   from otg_hpi_cs_export, active-low level
//   hpi_r_i        in     1   from otg_hpi_r_export, active-low level
//   hpi_w_i        in     1   from otg_hpi_w_export, active-low level
//   hpi_wdata_i    in     16  from otg_hpi_data_out_port
//   hpi_rdata_o    out    16  to otg_hpi_data_in_port, last captured read word
//   busy_o         out    1   high while not IDLE
//   otg_addr       out    2   HPI address pins
//   otg_cs_n       out    1   HPI chip select
//   otg_rd_n       out    1   HPI read strobe
//   otg_wr_n       out    1   HPI write strobe
//   otg_rst_n      out    1   controller reset
//   otg_data       inout  16  HPI data bus, tristated unless writing
// BEHAVIOUR
//   Reset (async): state=RST_HOLD; otg_cs_n/rd_n/wr_n=1; otg_addr=0; otg_data=Z;
//     hpi_rdata_o=0; busy_o=1; otg_rst_n=0; armed=0. All outputs are registered.
//   RST_HOLD: otg_rst_n=0 for RST_CYC cycles after reset release, then 1 -> IDLE.
//   Request: req = !hpi_cs_i & (!hpi_r_i ^ !hpi_w_i). If r and w are both low, the
//     request is illegal and ignored (no bus cycle).
//   armed is set in any cycle with hpi_cs_i=1. It is cleared when an access starts.
//   One access per cs-low period: software must raise cs before the next access.
//   IDLE: when req & armed, latch addr, dir (read if r low) and wdata; go to SETUP.
//     The start cycle does not count toward SETUP_CYC.
//   SETUP (SETUP_CYC): otg_cs_n=0, otg_addr=latched; write: otg_data driven.
//   STROBE (STROBE_CYC): otg_rd_n=0 (read) or otg_wr_n=0 (write).
//     Read: otg_data sampled into hpi_rdata_o on the edge leaving STROBE.
//   HOLD (HOLD_CYC): strobes=1; cs, addr and write data stay driven.
//   RECOVER (RECOVER_CYC): otg_cs_n=1, otg_data=Z, otg_addr keeps its value.
//     Exit to IDLE.
//   Latency: busy_o rises 1 cycle after the request is sampled and stays high for
//     SETUP+STROBE+HOLD+RECOVER cycles.
//     A read's hpi_rdata_o is valid SETUP+STROBE cycles after start.
//   hpi_* input changes during an access are ignored (latched values are used).
//     Only armed tracks hpi_cs_i.
//   otg_data is never driven during a read or when otg_cs_n=1. rd_n and wr_n are
//     never low together.
//   hpi_rdata_o holds its value until the next read completes. Writes leave it
//     unchanged.
//   Phase counter is 4 bits and reloads on every state entry; RST counter is 8 bits.
//   Reset mid-access: all outputs return to reset values immediately, the bus is
//     released and RST_HOLD restarts.
// TESTING
//   1. Reset release, defaults -> otg_rst_n low exactly 100 cycles; busy_o falls
//      the cycle after otg_rst_n rises.
//   2. Write: addr=2, wdata=16'hBEEF, cs/w low -> 2 cycles cs_n low before wr_n,
//      4 cycles wr_n low, data=BEEF from SETUP through HOLD, then 6 cycles cs_n high.
//   3. Read: addr=3, bus model drives 16'h1234 during strobe -> hpi_rdata_o=1234
//      6 cycles after start; otg_data never driven.
//   4. Hold cs low for 50 cycles after an access -> exactly one bus cycle.
//      Raising and re-lowering cs starts a second cycle.
//   5. Illegal request: r and w both low with cs low -> no strobe, busy_o stays 0.
//   6. Assert reset during STROBE of a write -> wr_n=1, cs_n=1, data=Z immediately;
//      otg_rst_n low for 100 cycles after release.

Source files
------------

// File: rtl/hpi_bus_ctrl_if.sv
// Bundle between the SoC HPI PIO ports and the CY7C67200 HPI pins, plus debug visibility.
// master = SoC/PIO side, slave = hpi_bus_ctrl.
interface hpi_bus_ctrl_if;
  logic [1:0]  hpi_address_i;
  logic        hpi_cs_i;
  logic        hpi_r_i;
  logic        hpi_w_i;
  logic [15:0] hpi_wdata_i;
  logic [15:0] hpi_rdata_o;
  logic        busy_o;
  logic [1:0]  otg_addr;
  logic        otg_cs_n;
  logic        otg_rd_n;
  logic        otg_wr_n;
  logic        otg_rst_n;
  logic        data_oe;
  logic [2:0]  dbg_state;

  modport master (
    output hpi_address_i, hpi_cs_i, hpi_r_i, hpi_w_i, hpi_wdata_i,
    input  hpi_rdata_o, busy_o, otg_addr, otg_cs_n, otg_rd_n, otg_wr_n,
           otg_rst_n, data_oe, dbg_state
  );

  modport slave (
    input  hpi_address_i, hpi_cs_i, hpi_r_i, hpi_w_i, hpi_wdata_i,
    output hpi_rdata_o, busy_o, otg_addr, otg_cs_n, otg_rd_n, otg_wr_n,
           otg_rst_n, data_oe, dbg_state
  );
endinterface

// File: rtl/hpi_bus_ctrl.sv
// Turns software-driven HPI PIO levels into one timed HPI bus cycle
// (setup, strobe, hold, recover) and holds the last read word for the SoC.
module hpi_bus_ctrl #(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned STROBE_CYC  = 4,
  parameter int unsigned HOLD_CYC    = 1,
  parameter int unsigned RECOVER_CYC = 6,
  parameter int unsigned RST_CYC     = 100
) (
  input  logic           clk_clk,
  input  logic           reset_reset_n,
  hpi_bus_ctrl_if.slave  bus,
  inout  wire [15:0]     otg_data
);

  localparam logic [2:0] ST_RST_HOLD = 3'd0;
  localparam logic [2:0] ST_IDLE     = 3'd1;
  localparam logic [2:0] ST_SETUP    = 3'd2;
  localparam logic [2:0] ST_STROBE   = 3'd3;
  localparam logic [2:0] ST_HOLD     = 3'd4;
  localparam logic [2:0] ST_RECOVER  = 3'd5;

  localparam logic [3:0] SETUP_LD   = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD  = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD    = 4'(HOLD_CYC - 1);
  localparam logic [3:0] RECOVER_LD = 4'(RECOVER_CYC - 1);
  localparam logic [7:0] RST_LD     = 8'(RST_CYC - 1);

  logic [2:0]  state;
  logic [3:0]  phase_cnt;
  logic [7:0]  rst_cnt;
  logic        armed;
  logic        dir_rd;
  logic [1:0]  addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic        cs_n_q;
  logic        rd_n_q;
  logic        wr_n_q;
  logic        rst_n_q;
  logic        busy_q;
  logic        oe_q;
  logic        req;
  logic        phase_done;

  // Request protocol: a request is the level cs low with exactly one of r/w low.
  // It is accepted only in IDLE while armed (cs was seen high since the last
  // accepted access), so a single cs-low period yields at most one bus cycle.
  assign req        = !bus.hpi_cs_i & (!bus.hpi_r_i ^ !bus.hpi_w_i);
  assign phase_done = (phase_cnt == 4'd0);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state     <= ST_RST_HOLD;
      phase_cnt <= 4'd0;
      rst_cnt   <= 8'd0;
      armed     <= 1'b0;
      dir_rd    <= 1'b0;
      addr_q    <= 2'd0;
      wdata_q   <= 16'd0;
      rdata_q   <= 16'd0;
      cs_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      rst_n_q   <= 1'b0;
      busy_q    <= 1'b1;
      oe_q      <= 1'b0;
    end else begin
      if (bus.hpi_cs_i) armed <= 1'b1;
      case (state)
        ST_RST_HOLD: begin
          // otg_rst_n rises first; busy drops one cycle later on the way to IDLE.
          if (rst_n_q) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else if (rst_cnt == RST_LD) begin
            rst_n_q <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + 8'd1;
          end
        end
        ST_IDLE: begin
          if (req && armed) begin
            armed     <= 1'b0;
            state     <= ST_SETUP;
            phase_cnt <= SETUP_LD;
            busy_q    <= 1'b1;
            dir_rd    <= !bus.hpi_r_i;
            addr_q    <= bus.hpi_address_i;
            wdata_q   <= bus.hpi_wdata_i;
            cs_n_q    <= 1'b0;
            oe_q      <= !bus.hpi_w_i;
          end
        end
        ST_SETUP: begin
          if (phase_done) begin
            state     <= ST_STROBE;
            phase_cnt <= STROBE_LD;
            rd_n_q    <= !dir_rd;
            wr_n_q    <= dir_rd;
          end else begin
            phase_cnt <= phase_cnt - 4'd1;
          end
        end
        ST_STROBE: begin
          if (phase_done) begin
            state     <= ST_HOLD;
            phase_cnt <= HOLD_LD;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            if (dir_rd) rdata_q <= otg_data;
          end else begin
            phase_cnt <= phase_cnt - 4'd1;
          end
        end
        ST_HOLD: begin
          if (phase_done) begin
            state     <= ST_RECOVER;
            phase_cnt <= RECOVER_LD;
            cs_n_q    <= 1'b1;
            oe_q      <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt - 4'd1;
          end
        end
        ST_RECOVER: begin
          if (phase_done) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt - 4'd1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          cs_n_q <= 1'b1;
          rd_n_q <= 1'b1;
          wr_n_q <= 1'b1;
          oe_q   <= 1'b0;
        end
      endcase
    end
  end

  assign otg_data        = oe_q ? wdata_q : {16{1'bz}};
  assign bus.hpi_rdata_o = rdata_q;
  assign bus.busy_o      = busy_q;
  assign bus.otg_addr    = addr_q;
  assign bus.otg_cs_n    = cs_n_q;
  assign bus.otg_rd_n    = rd_n_q;
  assign bus.otg_wr_n    = wr_n_q;
  assign bus.otg_rst_n   = rst_n_q;
  assign bus.data_oe     = oe_q;
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_hpi_bus_ctrl.sv
// Bench for hpi_bus_ctrl: PIO driver tasks, HPI bus model, and a monitor that
// measures each bus cycle and scores it against expectations queued at issue time.
module tb_hpi_bus_ctrl;
  localparam int SETUP_CYC   = 2;
  localparam int STROBE_CYC  = 4;
  localparam int HOLD_CYC    = 1;
  localparam int RECOVER_CYC = 6;
  localparam int RST_CYC     = 100;
  localparam int BUSY_CYC    = SETUP_CYC + STROBE_CYC + HOLD_CYC + RECOVER_CYC;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #10 clk = ~clk;

  wire [15:0]  otg_data;
  logic [15:0] model_rd_val = 16'd0;

  hpi_bus_ctrl_if bus ();

  hpi_bus_ctrl #(
    .SETUP_CYC(SETUP_CYC), .STROBE_CYC(STROBE_CYC), .HOLD_CYC(HOLD_CYC),
    .RECOVER_CYC(RECOVER_CYC), .RST_CYC(RST_CYC)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(reset_n),
    .bus          (bus),
    .otg_data     (otg_data)
  );

  // CY7C67200 side: presents the read word only while rd_n is low.
  assign otg_data = (!bus.otg_rd_n) ? model_rd_val : 16'hzzzz;

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  // entry = {is_read, addr[1:0], write_data[15:0], expected_rdata[15:0]}
  logic [34:0] exp_q[$];
  logic [15:0] last_rd = 16'd0;
  int mon_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- monitor ----------------
  logic        in_cyc = 1'b0;
  logic        have_exp = 1'b0;
  logic [34:0] cur_exp = '0;
  logic [1:0]  m_addr;
  int          m_setup, m_strobe, m_hold, m_rec, m_busy;
  bit          m_rd, m_wr, m_data_bad, m_addr_bad;

  always @(negedge clk) begin
    if (!reset_n) begin
      in_cyc = 1'b0;
    end else begin
      if (!in_cyc && !bus.otg_cs_n) begin
        in_cyc = 1'b1;
        mon_cycles++;
        m_setup = 0; m_strobe = 0; m_hold = 0; m_rec = 0; m_busy = 0;
        m_rd = 0; m_wr = 0; m_data_bad = 0; m_addr_bad = 0;
        m_addr = bus.otg_addr;
        check("cycle_expected", 32'(exp_q.size() > 0), 1);
        have_exp = (exp_q.size() > 0);
        if (have_exp) cur_exp = exp_q.pop_front();
      end
      if (in_cyc) begin
        if (bus.busy_o) m_busy++;
        if (bus.otg_addr != m_addr) m_addr_bad = 1;
        if (!bus.otg_cs_n) begin
          if (!bus.otg_rd_n || !bus.otg_wr_n) begin
            m_strobe++;
            if (!bus.otg_rd_n) m_rd = 1;
            if (!bus.otg_wr_n) m_wr = 1;
          end else if (m_strobe == 0) begin
            m_setup++;
          end else begin
            m_hold++;
            if (m_hold == 1 && have_exp && cur_exp[34])
              check("rdata_at_setup_plus_strobe", bus.hpi_rdata_o, cur_exp[15:0]);
          end
          if (have_exp && !cur_exp[34] && (!bus.data_oe || otg_data !== cur_exp[31:16]))
            m_data_bad = 1;
        end else if (bus.busy_o) begin
          m_rec++;
        end else begin
          in_cyc = 1'b0;
          if (have_exp) begin
            check("addr", m_addr, cur_exp[33:32]);
            check("addr_stable", m_addr_bad, 0);
            check("dir_rd_strobe", m_rd, cur_exp[34]);
            check("dir_wr_strobe", m_wr, !cur_exp[34]);
            check("setup_cycles", m_setup, SETUP_CYC);
            check("strobe_cycles", m_strobe, STROBE_CYC);
            check("hold_cycles", m_hold, HOLD_CYC);
            check("recover_cycles", m_rec, RECOVER_CYC);
            check("busy_cycles", m_busy, BUSY_CYC);
            if (!cur_exp[34]) check("wdata_on_bus", m_data_bad, 0);
            check("rdata_held", bus.hpi_rdata_o, cur_exp[15:0]);
          end
        end
      end
      check("strobe_overlap", 32'(!bus.otg_rd_n && !bus.otg_wr_n), 0);
      check("illegal_drive",
            32'(bus.data_oe && (bus.otg_cs_n || !bus.otg_rd_n || (in_cyc && have_exp && cur_exp[34]))), 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pio_idle();
    bus.hpi_cs_i = 1'b1; bus.hpi_r_i = 1'b1; bus.hpi_w_i = 1'b1;
  endtask

  task automatic reset_release_check();
    int n;
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    while (!bus.otg_rst_n && n < 300) begin
      n++;
      @(negedge clk);
    end
    check("otg_rst_low_cycles", n, RST_CYC);
    check("busy_when_rst_rises", bus.busy_o, 1);
    @(negedge clk);
    check("busy_after_rst_rise", bus.busy_o, 0);
  endtask

  task automatic do_access(input logic is_rd, input logic [1:0] a, input logic [15:0] d,
                           input int pre_gap, input int post_low, input bit scramble);
    int n;
    @(negedge clk);
    pio_idle();
    repeat (pre_gap) @(negedge clk);
    if (is_rd) begin
      model_rd_val = d;
      last_rd = d;
    end
    exp_q.push_back({is_rd, a, (is_rd ? 16'h0000 : d), last_rd});
    bus.hpi_address_i = a;
    bus.hpi_wdata_i   = is_rd ? 16'($urandom) : d;
    bus.hpi_r_i       = !is_rd;
    bus.hpi_w_i       = is_rd;
    bus.hpi_cs_i      = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.busy_o && n < 4);
    check("start_latency", n, 1);
    n = 0;
    while (bus.busy_o && n < 40) begin
      if (scramble) begin
        bus.hpi_address_i = 2'($urandom);
        bus.hpi_wdata_i   = 16'($urandom);
        {bus.hpi_r_i, bus.hpi_w_i} = 2'($urandom);
      end
      @(negedge clk);
      n++;
    end
    check("access_completes", bus.busy_o, 0);
    repeat (post_low) @(negedge clk);
    bus.hpi_r_i = 1'b1;
    bus.hpi_w_i = 1'b1;
  endtask

  task automatic illegal_attempt(input int len);
    int bad;
    @(negedge clk);
    pio_idle();
    repeat (2) @(negedge clk);
    bus.hpi_cs_i = 1'b0; bus.hpi_r_i = 1'b0; bus.hpi_w_i = 1'b0;
    bad = 0;
    repeat (len) begin
      @(negedge clk);
      if (bus.busy_o || !bus.otg_cs_n || !bus.otg_rd_n || !bus.otg_wr_n) bad++;
    end
    check("illegal_no_cycle", bad, 0);
    bus.hpi_r_i = 1'b1; bus.hpi_w_i = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n0;
    int n;
    reset_n = 1'b0;
    pio_idle();
    bus.hpi_address_i = 2'd0;
    bus.hpi_wdata_i   = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy_o, 1);
    check("rst_cs_n", bus.otg_cs_n, 1);
    check("rst_rd_n", bus.otg_rd_n, 1);
    check("rst_wr_n", bus.otg_wr_n, 1);
    check("rst_otg_rst_n", bus.otg_rst_n, 0);
    check("rst_addr", bus.otg_addr, 0);
    check("rst_rdata", bus.hpi_rdata_o, 0);
    check("rst_data_oe", bus.data_oe, 0);
    reset_release_check();

    do_access(1'b0, 2'd2, 16'hBEEF, 2, 0, 1'b0);
    do_access(1'b1, 2'd3, 16'h1234, 2, 0, 1'b0);

    n0 = mon_cycles;
    do_access(1'b0, 2'd1, 16'h5A5A, 1, 50, 1'b0);
    check("one_cycle_per_cs_low", mon_cycles - n0, 1);
    do_access(1'b1, 2'd0, 16'hC3C3, 1, 0, 1'b0);
    check("second_cycle_after_rearm", mon_cycles - n0, 2);

    illegal_attempt(30);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 7) == 0)
        illegal_attempt(5);
      else
        do_access(1'($urandom_range(0, 1)), 2'($urandom), 16'($urandom),
                  $urandom_range(1, 4), $urandom_range(0, 3), 1'b1);
    end

    // Reset asserted while a write strobe is on the bus.
    @(negedge clk);
    pio_idle();
    repeat (2) @(negedge clk);
    exp_q.push_back({1'b0, 2'd1, 16'hA5A5, last_rd});
    bus.hpi_address_i = 2'd1; bus.hpi_wdata_i = 16'hA5A5;
    bus.hpi_w_i = 1'b0; bus.hpi_cs_i = 1'b0;
    n = 0;
    while (bus.otg_wr_n && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("wr_strobe_reached", bus.otg_wr_n, 0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_wr_n", bus.otg_wr_n, 1);
    check("midrst_cs_n", bus.otg_cs_n, 1);
    check("midrst_data_oe", bus.data_oe, 0);
    check("midrst_otg_rst_n", bus.otg_rst_n, 0);
    check("midrst_busy", bus.busy_o, 1);
    check("midrst_rdata", bus.hpi_rdata_o, 0);
    exp_q.delete();
    last_rd = 16'd0;
    pio_idle();
    repeat (3) @(negedge clk);
    reset_release_check();

    do_access(1'b0, 2'd3, 16'h0F0F, 1, 0, 1'b0);
    do_access(1'b1, 2'd2, 16'h8001, 1, 0, 1'b0);

    repeat (5) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
